ifetch_prefetch: RTL and testbench

- Instruction fetch front-end that sits directly upstream of the CPU decode/execute datapath and replaces the combinational imem lookup.
- Issues word fetches to a variable-latency instruction memory using request/response handshakes.
- Buffers returned instructions with their PCs in a small prefetch queue.
- Presents instructions to the consumer through a valid/ready interface and supports PC redirects from branches and jumps.

---
 rtl/ifetch_pkg.sv | 30 +++
 rtl/fetch_queue.sv | 91 +++++++++
 rtl/ifetch_prefetch.sv | 162 ++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction fetch front-end.
//   fetch_state_t    : request FSM states (IDLE, REQ, WAIT)
//   NOP_INSTR        : addi x0,x0,0, presented when no instruction is valid
//   DEFAULT_RESET_PC : start of the text segment
//   fetch_entry_t    : one prefetch queue entry {pc, instr}
//   word_align()     : clears the two low address bits
// ---------------------------------------------------------------------------
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO of fetch_entry_t used as the prefetch buffer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears pointers/count)
//   flush      : empties the queue at the clock edge; overrides push and pop
//   push       : write push_data at the tail (ignored when full without pop)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (undefined contents while empty)
//   empty/full : occupancy flags
//   count      : number of valid entries, 0..DEPTH
// A push is only visible at the head after the clock edge that stores it.
// ---------------------------------------------------------------------------
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;
    fetch_entry_t  slot [DEPTH];

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;

    assign do_pop  = pop && !empty && !flush;
    // A full queue can still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop) && !flush;

    // Storage needs no reset: only entries between the pointers are ever read.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            fetch_entry_t entry_reg;
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg <= push_data;
                end
            end
            assign slot[gi] = entry_reg;
        end
    endgenerate

    assign head = slot[rd_ptr_reg];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch
// Instruction fetch front-end: issues one word fetch at a time to a
// variable-latency instruction memory, buffers {pc, instr} in a prefetch
// queue and hands instructions to the decoder over valid/ready.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   mem_req_valid/ready/addr : fetch request handshake (word-aligned address)
//   mem_rsp_valid/data       : one response per accepted request
//   redirect_valid/pc        : taken branch / jump; flushes and refetches
//   instr_valid/ready        : head-of-queue handshake to the consumer
//   instr, instr_pc          : head instruction (nop when empty) and its PC
//   instr_pc_plus4           : instr_pc + 4 (wraps modulo 2^32)
// ---------------------------------------------------------------------------
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;

    fetch_state_t state_reg;
    logic [31:0]  fetch_pc_reg;     // next address to request
    logic [31:0]  req_addr_reg;     // address of the request in flight
    logic         req_valid_reg;
    logic         discard_reg;      // the in-flight response belongs to a stale path

    fetch_entry_t q_head;
    fetch_entry_t q_push_data;
    logic         q_empty;
    logic         q_full;
    logic         q_push;
    logic         q_pop;
    logic [CW-1:0] q_count;

    logic [31:0]  redirect_target;
    logic [CW1-1:0] count_after_rsp;
    logic         space_after_rsp;

    assign redirect_target = word_align(redirect_pc);

    // A response is only queued in WAIT, on the live path, and not when a
    // redirect flushes the queue in the same cycle.
    assign q_pop       = instr_ready && !q_empty;
    assign q_push      = (state_reg == WAIT) && mem_rsp_valid && !discard_reg && !redirect_valid;
    assign q_push_data = '{pc: req_addr_reg, instr: mem_rsp_data};

    // Occupancy after this cycle's push/pop decides whether to fetch again.
    assign count_after_rsp = {1'b0, q_count} + CW1'(q_push) - CW1'(q_pop);
    assign space_after_rsp = (count_after_rsp < CW1'(DEPTH));

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= RESET_PC;
            req_addr_reg  <= RESET_PC;
            req_valid_reg <= 1'b0;
            discard_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A redirect flushes the queue, so there is always room for it.
                    if (redirect_valid) begin
                        fetch_pc_reg  <= redirect_target;
                        req_addr_reg  <= redirect_target;
                        req_valid_reg <= 1'b1;
                        state_reg     <= REQ;
                    end else if (!q_full) begin
                        req_addr_reg  <= fetch_pc_reg;
                        req_valid_reg <= 1'b1;
                        state_reg     <= REQ;
                    end
                end

                REQ: begin
                    // The request already on the bus must complete unchanged;
                    // its response is marked for dropping instead.
                    if (redirect_valid) begin
                        fetch_pc_reg <= redirect_target;
                        discard_reg  <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= WAIT;
                        // Once redirected, fetch_pc already holds the new path.
                        if (!redirect_valid && !discard_reg) begin
                            fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        end
                    end
                end

                WAIT: begin
                    if (mem_rsp_valid) begin
                        discard_reg <= 1'b0;
                        if (redirect_valid) begin
                            fetch_pc_reg  <= redirect_target;
                            req_addr_reg  <= redirect_target;
                            req_valid_reg <= 1'b1;
                            state_reg     <= REQ;
                        end else if (space_after_rsp) begin
                            req_addr_reg  <= fetch_pc_reg;
                            req_valid_reg <= 1'b1;
                            state_reg     <= REQ;
                        end else begin
                            state_reg     <= IDLE;
                        end
                    end else if (redirect_valid) begin
                        fetch_pc_reg <= redirect_target;
                        discard_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    req_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid  = req_valid_reg;
    assign mem_req_addr   = req_addr_reg;

    assign instr_valid    = !q_empty;
    assign instr          = q_empty ? NOP_INSTR : q_head.instr;
    assign instr_pc       = q_empty ? RESET_PC  : q_head.pc;
    assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch_prefetch
// Directed bench for ifetch_prefetch: a per-cycle vector table for the
// streaming case, then hand-written sequences for back-pressure, stalls,
// redirects, reset mid-transfer and address wrap.
// ---------------------------------------------------------------------------
module tb_ifetch_prefetch;
    import ifetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_prefetch #(
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        i_ready;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_instr_valid;
        logic [31:0] exp_instr_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        check({tag, "_req_addr"}, mem_req_addr, RPC);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr, NOP_INSTR);
        check({tag, "_instr_pc"}, instr_pc, RPC);
        check({tag, "_pc_plus4"}, instr_pc_plus4, RPC + 32'd4);
    endtask

    // Ends at a negedge with reset released; the DUT is in IDLE.
    task automatic do_reset();
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        instr_ready    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    // Waits (bounded) for a request, checks its address, accepts it and
    // answers one cycle later. Returns at the negedge after the response edge.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data);
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("serve_req_valid", 32'(mem_req_valid), 32'd1);
        check("serve_req_addr", mem_req_addr, exp_addr);
        $display("fetch addr=%h data=%h", mem_req_addr, data);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        // Streaming: ready memory, 1-cycle responses, consumer always ready.
        vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0040_0000, 1'b0, 32'h0,         NOP_INSTR};
        vecs[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0,         NOP_INSTR};
        vecs[2] = '{1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0040_0000, 1'b0, 32'h0,         NOP_INSTR};
        vecs[3] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0004, 1'b1, 32'h0040_0000, 32'h1111_1111};
        vecs[4] = '{1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0040_0004, 1'b0, 32'h0,         NOP_INSTR};
        vecs[5] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0004, 32'h2222_2222};
        vecs[6] = '{1'b1, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0040_0008, 1'b0, 32'h0,         NOP_INSTR};
        vecs[7] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_000C, 1'b1, 32'h0040_0008, 32'h3333_3333};

        // ---- table: streaming ---------------------------------------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream%0d_req_valid", i), 32'(mem_req_valid), 32'(vecs[i].exp_req_valid));
            check($sformatf("stream%0d_req_addr", i), mem_req_addr, vecs[i].exp_req_addr);
            check($sformatf("stream%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_instr_valid));
            check($sformatf("stream%0d_instr", i), instr, vecs[i].exp_instr);
            if (vecs[i].exp_instr_valid) begin
                check($sformatf("stream%0d_instr_pc", i), instr_pc, vecs[i].exp_instr_pc);
                check($sformatf("stream%0d_pc_plus4", i), instr_pc_plus4, vecs[i].exp_instr_pc + 32'd4);
            end
            $display("cycle %0d req=%b addr=%h ivalid=%b pc=%h instr=%h",
                     i, mem_req_valid, mem_req_addr, instr_valid, instr_pc, instr);
            mem_req_ready = vecs[i].req_ready;
            mem_rsp_valid = vecs[i].rsp_valid;
            mem_rsp_data  = vecs[i].rsp_data;
            instr_ready   = vecs[i].i_ready;
            @(negedge clk);
        end

        // ---- consumer stalled: queue fills, fetching stops, then drains ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            serve(RPC + 32'(4 * k), 32'hA000_0000 + 32'(k));
        end
        for (int k = 0; k < 5; k++) begin
            check("full_no_req", 32'(mem_req_valid), 32'd0);
            check("full_head_pc", instr_pc, RPC);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 32'(instr_valid), 32'd1);
            check("drain_pc", instr_pc, RPC + 32'(4 * k));
            check("drain_instr", instr, 32'hA000_0000 + 32'(k));
            @(negedge clk);
        end
        instr_ready = 1'b0;
        check("drain_empty", 32'(instr_valid), 32'd0);
        check("resume_req_valid", 32'(mem_req_valid), 32'd1);
        check("resume_req_addr", mem_req_addr, RPC + 32'h10);

        // ---- memory not ready: request held stable -------------------------
        do_reset();
        instr_ready = 1'b1;
        serve(RPC, 32'hB000_0000);
        serve(RPC + 32'd4, 32'hB000_0004);
        for (int k = 0; k < 5; k++) begin
            check("stall_req_valid", 32'(mem_req_valid), 32'd1);
            check("stall_req_addr", mem_req_addr, RPC + 32'd8);
            @(negedge clk);
        end
        serve(RPC + 32'd8, 32'hB000_0008);
        check("stall_instr_pc", instr_pc, RPC + 32'd8);
        check("stall_instr", instr, 32'hB000_0008);

        // ---- redirect in WAIT, response 3 cycles after acceptance ----------
        do_reset();
        serve(RPC, 32'hC000_0000);
        check("wait_rd_pre_valid", 32'(instr_valid), 32'd1);
        check("wait_rd_pre_addr", mem_req_addr, RPC + 32'd4);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("wait_rd_flushed", 32'(instr_valid), 32'd0);
        check("wait_rd_no_req", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_0004;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("wait_rd_dropped", 32'(instr_valid), 32'd0);
        check("wait_rd_new_req", mem_req_addr, 32'h0040_0040);
        serve(32'h0040_0040, 32'hC000_0040);
        check("wait_rd_instr_pc", instr_pc, 32'h0040_0040);
        check("wait_rd_instr", instr, 32'hC000_0040);

        // ---- redirect + response + pop in the same cycle -------------------
        do_reset();
        serve(RPC, 32'hD000_0000);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b1;
        mem_rsp_data   = 32'hDEAD_0004;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0083;
        instr_ready    = 1'b1;
        @(negedge clk);
        mem_rsp_valid  = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        check("same_rd_valid", 32'(instr_valid), 32'd0);
        check("same_rd_nop", instr, NOP_INSTR);
        check("same_rd_req_valid", 32'(mem_req_valid), 32'd1);
        check("same_rd_req_addr", mem_req_addr, 32'h0040_0080);
        serve(32'h0040_0080, 32'hD000_0080);
        check("same_rd_instr_pc", instr_pc, 32'h0040_0080);
        check("same_rd_pc_plus4", instr_pc_plus4, 32'h0040_0084);

        // ---- reset asserted in WAIT, stray response in IDLE ----------------
        do_reset();
        serve(RPC, 32'hE000_0000);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("stray_ignored", 32'(instr_valid), 32'd0);
        check("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
        check("post_rst_req_addr", mem_req_addr, RPC);
        serve(RPC, 32'hE000_1000);
        check("post_rst_instr_pc", instr_pc, RPC);
        check("post_rst_instr", instr, 32'hE000_1000);

        // ---- redirect in IDLE and address wrap -----------------------------
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("idle_rd_req_valid", 32'(mem_req_valid), 32'd1);
        check("idle_rd_req_addr", mem_req_addr, 32'hFFFF_FFFC);
        serve(32'hFFFF_FFFC, 32'hF000_FFFC);
        check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", instr_pc_plus4, 32'h0000_0000);
        check("wrap_next_addr", mem_req_addr, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
